// File: rtl/pc_seq_pkg.sv
// Shared types and default vectors for the PC sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {IDLE, BOOT, RUN, HOLD} state_e;

  // Ordinal order is priority order: a larger value outranks a smaller one.
  typedef enum logic [1:0] {NONE, BR, JMP, EXC} redir_e;

  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0080;
  localparam logic [31:0] PC_STEP_DEF   = 32'd4;

  // Highest-priority redirect among the simultaneous requests.
  function automatic redir_e redir_kind(input logic exc, input logic jmp, input logic br);
    if (exc)      return EXC;
    else if (jmp) return JMP;
    else if (br)  return BR;
    else          return NONE;
  endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// Pending-redirect buffer: holds one target captured while the pipe is
// stalled; a new capture replaces it only at higher or equal priority.
module pc_redirect_buf
  import pc_seq_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        cap_i,
  input  logic        take_i,
  input  logic [1:0]  kind_i,
  input  logic [31:0] tgt_i,
  output logic        vld_o,
  output logic [31:0] tgt_o
);

  redir_e      kind_q, kind_d;
  logic [31:0] tgt_q, tgt_d;

  // Clear wins over capture; capture and take never coincide (stall vs no stall).
  always_comb begin
    kind_d = kind_q;
    tgt_d  = tgt_q;
    if (clr_i || take_i) begin
      kind_d = NONE;
    end else if (cap_i && (redir_e'(kind_i) != NONE) && (redir_e'(kind_i) >= kind_q)) begin
      kind_d = redir_e'(kind_i);
      tgt_d  = tgt_i;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      kind_q <= NONE;
      tgt_q  <= '0;
    end else begin
      kind_q <= kind_d;
      tgt_q  <= tgt_d;
    end
  end

  assign vld_o = (kind_q != NONE);
  assign tgt_o = tgt_q;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller ahead of the PC register.
// While dcache_stall_i is high in RUN/HOLD the pipe is frozen and any
// redirect is buffered; the first unstalled cycle issues the buffered target.
// Optional build macro PC_SEQUENCER_PERF_EN adds a saturating stall counter.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF,
  parameter logic [31:0] PC_STEP   = PC_STEP_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  input  logic        dcache_stall_i,
  input  logic        hazard_i,
  input  logic        branch_i,
  input  logic [31:0] branch_tgt_i,
  input  logic        jump_i,
  input  logic [31:0] jump_tgt_i,
  input  logic        exc_i,
  output logic [31:0] pc_next_o,
  output logic        start_o,
  output logic        pc_enable_o,
  output logic        stall_o,
  output logic        flush_if_o,
  output logic        redir_pend_o
`ifdef PC_SEQUENCER_PERF_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  state_e      state_q, state_d;
  redir_e      new_kind;
  logic [31:0] new_tgt;
  logic        active, held, issue_pend;
  logic        pend_vld;
  logic [31:0] pend_tgt;

  assign new_kind   = redir_kind(exc_i, jump_i, branch_i);
  assign active     = (state_q == RUN) || (state_q == HOLD);
  assign held       = active && dcache_stall_i;
  assign issue_pend = active && !dcache_stall_i && pend_vld;

  // Target of the highest-priority incoming redirect.
  always_comb begin
    new_tgt = branch_tgt_i;
    case (new_kind)
      EXC:     new_tgt = EXC_VEC;
      JMP:     new_tgt = jump_tgt_i;
      default: new_tgt = branch_tgt_i;
    endcase
  end

  pc_redirect_buf u_buf (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (!start_i || (state_q == IDLE)),
    .cap_i  (held),
    .take_i (issue_pend),
    .kind_i (new_kind),
    .tgt_i  (new_tgt),
    .vld_o  (pend_vld),
    .tgt_o  (pend_tgt)
  );

  // Next state; dropping start_i returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = BOOT;
      BOOT:    state_d = RUN;
      RUN:     if (dcache_stall_i) state_d = HOLD;
      HOLD:    if (!dcache_stall_i) state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (!start_i) state_d = IDLE;
  end

  // Outputs: stall > pending redirect > new redirect > hazard > sequential.
  always_comb begin
    pc_next_o   = RESET_VEC;
    start_o     = 1'b0;
    pc_enable_o = 1'b0;
    stall_o     = 1'b0;
    flush_if_o  = 1'b0;
    case (state_q)
      BOOT: begin
        start_o     = 1'b1;
        pc_enable_o = 1'b1;
      end
      RUN, HOLD: begin
        start_o = 1'b1;
        if (held) begin
          stall_o   = 1'b1;
          pc_next_o = pc_i;
        end else if (issue_pend) begin
          pc_enable_o = 1'b1;
          flush_if_o  = 1'b1;
          pc_next_o   = exc_i ? EXC_VEC : pend_tgt;
        end else if (new_kind != NONE) begin
          pc_enable_o = 1'b1;
          flush_if_o  = 1'b1;
          pc_next_o   = new_tgt;
        end else if (hazard_i) begin
          stall_o   = 1'b1;
          pc_next_o = pc_i;
        end else begin
          pc_enable_o = 1'b1;
          pc_next_o   = pc_i + PC_STEP;
        end
      end
      default: ;
    endcase
  end

  assign redir_pend_o = pend_vld;

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

`ifdef PC_SEQUENCER_PERF_EN
  logic [31:0] cnt_q, cnt_d;

  // Saturating count of stalled cycles, zeroed on entry to IDLE.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == IDLE)                cnt_d = '0;
    else if (stall_o && (cnt_q != '1))  cnt_d = cnt_q + 32'd1;
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign stall_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, a reset-in-HOLD
// sequence, then random stimulus against a behavioural model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0, dst = 1'b0, haz = 1'b0, br = 1'b0, jp = 1'b0, exc = 1'b0;
  logic [31:0] pc_i = '0, bt = '0, jt = '0;
  logic [31:0] pc_next;
  logic        start_o, pc_en, stall, flush, pend;
`ifdef PC_SEQUENCER_PERF_EN
  logic [31:0] stall_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start_i), .pc_i(pc_i),
    .dcache_stall_i(dst), .hazard_i(haz), .branch_i(br), .branch_tgt_i(bt),
    .jump_i(jp), .jump_tgt_i(jt), .exc_i(exc),
    .pc_next_o(pc_next), .start_o(start_o), .pc_enable_o(pc_en),
    .stall_o(stall), .flush_if_o(flush), .redir_pend_o(pend)
`ifdef PC_SEQUENCER_PERF_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  typedef struct {
    logic start, dst, haz, br, jp, exc;
    logic [31:0] pc, bt, jt;
  } in_t;

  typedef struct {
    in_t         i;
    logic [36:0] e;   // {pc_next, start, enable, stall, flush, pend}
  } vec_t;

  function automatic in_t mi(logic s, logic [31:0] p, logic d, logic h,
                             logic b, logic [31:0] btg, logic j, logic [31:0] jtg, logic x);
    in_t r;
    r.start = s; r.pc = p; r.dst = d; r.haz = h; r.br = b; r.bt = btg;
    r.jp = j; r.jt = jtg; r.exc = x;
    return r;
  endfunction

  function automatic logic [36:0] ex(logic [31:0] p, logic s, logic en, logic st, logic fl, logic pd);
    return {p, s, en, st, fl, pd};
  endfunction

  task automatic drive(input in_t v);
    start_i = v.start; pc_i = v.pc; dst = v.dst; haz = v.haz;
    br = v.br; bt = v.bt; jp = v.jp; jt = v.jt; exc = v.exc;
  endtask

  task automatic check(input string name, input logic [36:0] exp);
    logic [36:0] act;
    act = {pc_next, start_o, pc_en, stall, flush, pend};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got pc=%h st=%b en=%b stall=%b flush=%b pend=%b, want pc=%h st=%b en=%b stall=%b flush=%b pend=%b",
               name, act[36:5], act[4], act[3], act[2], act[1], act[0],
               exp[36:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model (random phase) ----------------
  // mode: 0 idle, 1 boot, 2 running (stalled or not); pending redirect kept
  // as (valid, priority 1..3, target).
  int          m_mode;
  bit          m_pv;
  int          m_pk;
  logic [31:0] m_pt;
  logic [31:0] m_cnt;

  function automatic int prio(in_t v);
    return v.exc ? 3 : v.jp ? 2 : v.br ? 1 : 0;
  endfunction

  function automatic logic [31:0] tgt(in_t v);
    return v.exc ? 32'h80 : v.jp ? v.jt : v.bt;
  endfunction

  function automatic logic [36:0] model_out(in_t v);
    if (m_mode == 0) return ex(32'h0, 0, 0, 0, 0, m_pv);
    if (m_mode == 1) return ex(32'h0, 1, 1, 0, 0, m_pv);
    if (v.dst)       return ex(v.pc, 1, 0, 1, 0, m_pv);
    if (m_pv)        return ex(v.exc ? 32'h80 : m_pt, 1, 1, 0, 1, m_pv);
    if (prio(v) > 0) return ex(tgt(v), 1, 1, 0, 1, m_pv);
    if (v.haz)       return ex(v.pc, 1, 0, 1, 0, m_pv);
    return ex(v.pc + 32'd4, 1, 1, 0, 0, m_pv);
  endfunction

  task automatic model_step(in_t v, logic stalled);
    if (!v.start || m_mode == 0) begin
      m_pv = 0;
      m_pk = 0;
    end else if (m_mode == 2) begin
      if (v.dst && prio(v) > 0 && (!m_pv || prio(v) >= m_pk)) begin
        m_pv = 1; m_pk = prio(v); m_pt = tgt(v);
      end else if (!v.dst && m_pv) begin
        m_pv = 0; m_pk = 0;
      end
    end
    if (!v.start)         m_mode = 0;
    else if (m_mode == 0) m_mode = 1;
    else                  m_mode = 2;
    if (m_mode == 0)                       m_cnt = 0;
    else if (stalled && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(mi(0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  vec_t tbl[$];

  initial begin
    in_t v;
    logic [36:0] e;

    // ---------------- directed table ----------------
    tbl.push_back('{mi(0, 0, 0,0, 0,0, 0,0, 0),              ex(0, 0,0,0,0,0)});
    tbl.push_back('{mi(1, 0, 0,0, 0,0, 0,0, 0),              ex(0, 0,0,0,0,0)});
    tbl.push_back('{mi(1, 0, 0,0, 0,0, 0,0, 0),              ex(0, 1,1,0,0,0)});
    tbl.push_back('{mi(1, 0, 0,0, 0,0, 0,0, 0),              ex(4, 1,1,0,0,0)});
    tbl.push_back('{mi(1, 'h100, 0,0, 1,'h40, 0,0, 0),       ex('h40, 1,1,0,1,0)});
    tbl.push_back('{mi(1, 'h100, 0,0, 1,'h40, 1,'h80, 0),    ex('h80, 1,1,0,1,0)});
    tbl.push_back('{mi(1, 'h10, 0,1, 0,0, 0,0, 0),           ex('h10, 1,0,1,0,0)});
    tbl.push_back('{mi(1, 'h10, 0,1, 1,'h40, 0,0, 0),        ex('h40, 1,1,0,1,0)});
    tbl.push_back('{mi(1, 32'hFFFF_FFFC, 0,0, 0,0, 0,0, 0),  ex(0, 1,1,0,0,0)});
    tbl.push_back('{mi(1, 'h120, 1,0, 0,0, 0,0, 0),          ex('h120, 1,0,1,0,0)});
    tbl.push_back('{mi(1, 'h120, 1,0, 1,'h200, 0,0, 0),      ex('h120, 1,0,1,0,0)});
    tbl.push_back('{mi(1, 'h120, 1,0, 0,0, 0,0, 0),          ex('h120, 1,0,1,0,1)});
    tbl.push_back('{mi(1, 'h120, 1,0, 0,0, 0,0, 0),          ex('h120, 1,0,1,0,1)});
    tbl.push_back('{mi(1, 'h120, 1,0, 0,0, 0,0, 0),          ex('h120, 1,0,1,0,1)});
    tbl.push_back('{mi(1, 'h120, 0,0, 0,0, 0,0, 0),          ex('h200, 1,1,0,1,1)});
    tbl.push_back('{mi(1, 'h120, 0,0, 0,0, 0,0, 0),          ex('h124, 1,1,0,0,0)});
    // jump then lower-priority branch: branch must not overwrite
    tbl.push_back('{mi(1, 'h120, 1,0, 0,0, 1,'h300, 0),      ex('h120, 1,0,1,0,0)});
    tbl.push_back('{mi(1, 'h120, 1,0, 1,'h400, 0,0, 0),      ex('h120, 1,0,1,0,1)});
    tbl.push_back('{mi(1, 'h120, 1,0, 0,0, 0,0, 0),          ex('h120, 1,0,1,0,1)});
    tbl.push_back('{mi(1, 'h120, 0,0, 0,0, 0,0, 0),          ex('h300, 1,1,0,1,1)});
    // jump then exception: exception overwrites
    tbl.push_back('{mi(1, 'h120, 1,0, 0,0, 1,'h300, 0),      ex('h120, 1,0,1,0,0)});
    tbl.push_back('{mi(1, 'h120, 1,0, 0,0, 0,0, 1),          ex('h120, 1,0,1,0,1)});
    tbl.push_back('{mi(1, 'h120, 0,0, 0,0, 0,0, 0),          ex('h80, 1,1,0,1,1)});
    // new exception at exit outranks a pending branch
    tbl.push_back('{mi(1, 'h120, 1,0, 1,'h500, 0,0, 0),      ex('h120, 1,0,1,0,0)});
    tbl.push_back('{mi(1, 'h120, 0,0, 0,0, 0,0, 1),          ex('h80, 1,1,0,1,1)});
    // new jump at exit does not outrank a pending branch
    tbl.push_back('{mi(1, 'h120, 1,0, 1,'h500, 0,0, 0),      ex('h120, 1,0,1,0,0)});
    tbl.push_back('{mi(1, 'h120, 0,0, 0,0, 1,'h700, 0),      ex('h500, 1,1,0,1,1)});
    // stall and hazard together, then hazard alone
    tbl.push_back('{mi(1, 'h120, 1,1, 0,0, 0,0, 0),          ex('h120, 1,0,1,0,0)});
    tbl.push_back('{mi(1, 'h120, 0,1, 0,0, 0,0, 0),          ex('h120, 1,0,1,0,0)});
    // start drop from RUN
    tbl.push_back('{mi(0, 'h120, 0,0, 0,0, 0,0, 0),          ex('h124, 1,1,0,0,0)});
    tbl.push_back('{mi(0, 'h120, 0,0, 0,0, 0,0, 0),          ex(0, 0,0,0,0,0)});
    tbl.push_back('{mi(1, 'h120, 0,0, 0,0, 0,0, 0),          ex(0, 0,0,0,0,0)});
    tbl.push_back('{mi(1, 'h120, 0,0, 0,0, 0,0, 0),          ex(0, 1,1,0,0,0)});
    // start drop from HOLD clears the pending redirect
    tbl.push_back('{mi(1, 'h120, 1,0, 1,'h900, 0,0, 0),      ex('h120, 1,0,1,0,0)});
    tbl.push_back('{mi(0, 'h120, 1,0, 0,0, 0,0, 0),          ex('h120, 1,0,1,0,1)});
    tbl.push_back('{mi(0, 'h120, 0,0, 0,0, 0,0, 0),          ex(0, 0,0,0,0,0)});

    do_reset();
    check("reset_state", ex(0, 0,0,0,0,0));
    @(posedge clk); #1;
    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].i);
      #2 check($sformatf("vec%0d", k), tbl[k].e);
      @(posedge clk); #1;
    end

    // ---------------- reset in HOLD with a pending redirect ----------------
    do_reset();
    drive(mi(1, 'h0, 0,0, 0,0, 0,0, 0));
    repeat (3) begin @(posedge clk); #1; end          // IDLE, BOOT, RUN
    for (int c = 1; c <= 5; c++) begin
      drive(mi(1, 'h20, 1,0, c == 2, 'h200, 0,0, 0));
      #2 check($sformatf("stall_c%0d", c), ex('h20, 1,0,1,0, c >= 3));
      @(posedge clk); #1;
    end
    drive(mi(1, 'h20, 1,0, 0,0, 0,0, 0));
    #2 check("hold_pend", ex('h20, 1,0,1,0,1));
`ifdef PC_SEQUENCER_PERF_EN
    check32("stall_cnt5", stall_cnt, 32'd5);
`endif
    rst_n = 1'b0;
    #1 check("async_reset", ex(0, 0,0,0,0,0));
`ifdef PC_SEQUENCER_PERF_EN
    check32("stall_cnt_rst", stall_cnt, 32'd0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;

    // ---------------- random vs model ----------------
    do_reset();
    m_mode = 0; m_pv = 0; m_pk = 0; m_pt = '0; m_cnt = '0;
    for (int k = 0; k < 600; k++) begin
      v.start = ($urandom_range(0, 39) != 0);
      v.dst   = ($urandom_range(0, 3) == 0);
      v.haz   = ($urandom_range(0, 5) == 0);
      v.br    = ($urandom_range(0, 4) == 0);
      v.jp    = ($urandom_range(0, 6) == 0);
      v.exc   = ($urandom_range(0, 12) == 0);
      v.pc    = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {$urandom(), 2'b00} ;
      v.bt    = $urandom();
      v.jt    = $urandom();
      drive(v);
      e = model_out(v);
      #2 check($sformatf("rand%0d", k), e);
`ifdef PC_SEQUENCER_PERF_EN
      check32($sformatf("rand_cnt%0d", k), stall_cnt, m_cnt);
`endif
      model_step(v, e[2]);
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
